// File: rtl/counter_74161_n.sv
// counter_74161_n: synchronous modulo-N up/down counter in the style of the
// 74161/74163 family. It has a synchronous clear, a synchronous parallel load,
// and two count enables: ENP gates counting only, while ENT gates both counting
// and RCO so that stages can be cascaded. RCO is combinational from Q, ENT and
// UP. TCP is a registered one-cycle pulse that follows every count wrap.
module counter_74161_n #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd16
) (
    input  logic             C,
    input  logic             nR,
    input  logic             nCLR,
    input  logic             nLOAD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TCP
);

    // Terminal value for counting up, and constants used by the wrap arithmetic.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    // The modulus is one bit wider than Q, so that MODULUS = 2^WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    // Reject illegal parameter values at elaboration time.
    generate
        if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
            $error("counter_74161_n: WIDTH must be in 1..32");
        end
        if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
            $error("counter_74161_n: MODULUS must be in 2..2^WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tcp_q;
    logic             tcp_d;
    logic             count_en_s;

    // Increment with wrap at MODULUS-1. Any value at or above the terminal
    // value also returns to zero, so Q can never leave the legal range.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v >= MAX_VAL) begin
            r = ZERO_VAL;
        end else begin
            r = v + ONE_VAL;
        end
        return r;
    endfunction

    // Decrement with wrap from zero to MODULUS-1. Any out-of-range value is
    // pulled back to the terminal value.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ((v == ZERO_VAL) || (v > MAX_VAL)) begin
            r = MAX_VAL;
        end else begin
            r = v - ONE_VAL;
        end
        return r;
    endfunction

    // Load data is accepted only when it lies below the modulus; any other value loads zero.
    function automatic logic [WIDTH-1:0] load_value(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} < MOD_EXT) begin
            r = v;
        end else begin
            r = ZERO_VAL;
        end
        return r;
    endfunction

    // Reports whether a count from v in direction up_i crosses the wrap point.
    function automatic logic at_terminal(input logic [WIDTH-1:0] v, input logic up_i);
        logic r;
        if (up_i) begin
            r = (v == MAX_VAL);
        end else begin
            r = (v == ZERO_VAL);
        end
        return r;
    endfunction

    assign count_en_s = ENP & ENT;

    // Next-state selection: clear, then load, then count, then hold.
    always_comb begin
        q_d   = q_q;
        tcp_d = 1'b0;
        if (!nCLR) begin
            q_d   = ZERO_VAL;
            tcp_d = 1'b0;
        end else if (!nLOAD) begin
            q_d   = load_value(D);
            tcp_d = 1'b0;
        end else if (count_en_s) begin
            if (UP) begin
                q_d = step_up(q_q);
            end else begin
                q_d = step_down(q_q);
            end
            tcp_d = at_terminal(q_q, UP);
        end else begin
            q_d   = q_q;
            tcp_d = 1'b0;
        end
    end

    // State registers. nR aborts any pending operation immediately.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            q_q   <= ZERO_VAL;
            tcp_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tcp_q <= tcp_d;
        end
    end

    assign Q   = q_q;
    assign TCP = tcp_q;
    // Carry/borrow out follows UP and ENT combinationally, for cascading stages.
    assign RCO = ENT & at_terminal(q_q, UP);

endmodule

// File: tb/tb_counter_74161_n.sv
// Self-checking bench for counter_74161_n. It drives a modulo-10 counter, a
// 1-bit toggle configuration and a two-stage cascaded 8-bit counter, and checks
// them against arithmetic reference models on every falling edge. Directed
// literal checks are added at the interesting points of each scenario.
module tb_counter_74161_n;

    logic       clk;
    logic       nr;
    logic       nclr;
    logic       nload;
    logic       enp;
    logic       ent;
    logic       up;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;
    logic       tcp;

    logic       t_en;
    logic [0:0] t_d;
    logic [0:0] t_q;
    logic       t_rco;
    logic       t_tcp;

    logic       c_en;
    logic       c_nload;
    logic [7:0] c_d;
    logic [3:0] ql;
    logic [3:0] qh;
    logic       rco_lo;
    logic       rco_hi;
    logic       tcp_lo;
    logic       tcp_hi;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_q;
    bit m_tcp;
    int tm_q;
    bit tm_tcp;
    int cm_val;

    counter_74161_n #(.WIDTH(4), .MODULUS(64'd10)) dut (
        .C(clk), .nR(nr), .nCLR(nclr), .nLOAD(nload), .ENP(enp), .ENT(ent),
        .UP(up), .D(d), .Q(q), .RCO(rco), .TCP(tcp)
    );

    counter_74161_n #(.WIDTH(1), .MODULUS(64'd2)) dut_t (
        .C(clk), .nR(nr), .nCLR(1'b1), .nLOAD(1'b1), .ENP(t_en), .ENT(t_en),
        .UP(1'b1), .D(t_d), .Q(t_q), .RCO(t_rco), .TCP(t_tcp)
    );

    counter_74161_n #(.WIDTH(4), .MODULUS(64'd16)) dut_lo (
        .C(clk), .nR(nr), .nCLR(1'b1), .nLOAD(c_nload), .ENP(c_en), .ENT(c_en),
        .UP(1'b1), .D(c_d[3:0]), .Q(ql), .RCO(rco_lo), .TCP(tcp_lo)
    );

    counter_74161_n #(.WIDTH(4), .MODULUS(64'd16)) dut_hi (
        .C(clk), .nR(nr), .nCLR(1'b1), .nLOAD(c_nload), .ENP(c_en), .ENT(rco_lo),
        .UP(1'b1), .D(c_d[7:4]), .Q(qh), .RCO(rco_hi), .TCP(tcp_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Modulo arithmetic reference model for the next count value.
    function automatic int next_q(input int cur, input int m, input bit clr_n, input bit ld_n,
                                  input bit cnt, input bit up_i, input int d_i);
        if (!clr_n) return 0;
        if (!ld_n) return (d_i < m) ? d_i : 0;
        if (cnt) return up_i ? (cur + 1) % m : (cur + m - 1) % m;
        return cur;
    endfunction

    function automatic bit wraps(input int cur, input int m, input bit clr_n, input bit ld_n,
                                 input bit cnt, input bit up_i);
        return clr_n && ld_n && cnt && (up_i ? (cur == m - 1) : (cur == 0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference models advance on the same edges as the counters.
    always @(posedge clk or negedge nr) begin
        if (!nr) begin
            m_q    <= 0;
            m_tcp  <= 1'b0;
            tm_q   <= 0;
            tm_tcp <= 1'b0;
            cm_val <= 0;
        end else begin
            m_q    <= next_q(m_q, 10, nclr, nload, enp && ent, up, int'(d));
            m_tcp  <= wraps(m_q, 10, nclr, nload, enp && ent, up);
            tm_q   <= next_q(tm_q, 2, 1'b1, 1'b1, t_en, 1'b1, 0);
            tm_tcp <= wraps(tm_q, 2, 1'b1, 1'b1, t_en, 1'b1);
            cm_val <= !c_nload ? int'(c_d) : (c_en ? (cm_val + 1) % 256 : cm_val);
        end
    end

    // Compare every output against the models on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", q, m_q);
            check("model_tcp", tcp, m_tcp);
            check("model_rco", rco, ent && (up ? (m_q == 9) : (m_q == 0)));
            check("model_t_q", t_q, tm_q);
            check("model_t_tcp", t_tcp, tm_tcp);
            check("model_t_rco", t_rco, t_en && (tm_q == 1));
            check("model_cascade", {qh, ql}, cm_val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nr = 1'b0; nclr = 1'b1; nload = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = 4'd0;
        t_en = 1'b0; t_d = 1'b0; c_en = 1'b0; c_nload = 1'b1; c_d = 8'h00;

        // Reset state, and RCO while reset is held.
        #7;
        check("reset_q", q, 0);
        check("reset_tcp", tcp, 0);
        up = 1'b0; ent = 1'b1;
        #1 check("reset_rco_down", rco, 1);
        up = 1'b1;
        #1 check("reset_rco_up", rco, 0);
        enp = 1'b1; t_en = 1'b1;
        #3 nr = 1'b1;
        chk_en = 1'b1;

        // Count up through the wrap.
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("up_step", q, i);
            if (i == 1) check("toggle_one", t_q, 1);
            if (i == 2) begin
                check("toggle_zero", t_q, 0);
                check("toggle_tcp", t_tcp, 1);
            end
        end
        t_en = 1'b0;
        check("rco_at_9", rco, 1);
        check("tcp_before_wrap", tcp, 0);
        check("model_pin_9", m_q, 9);
        tick();
        check("wrap_up_q", q, 0);
        check("wrap_up_tcp", tcp, 1);
        tick();
        check("after_wrap_q", q, 1);
        check("after_wrap_tcp", tcp, 0);

        // Load 2, then count down through the wrap.
        up = 1'b0; nload = 1'b0; d = 4'd2;
        tick();
        check("load_2", q, 2);
        nload = 1'b1;
        tick();
        check("down_1", q, 1);
        tick();
        check("down_0", q, 0);
        check("rco_at_0", rco, 1);
        check("tcp_down_0", tcp, 0);
        tick();
        check("wrap_down_q", q, 9);
        check("wrap_down_tcp", tcp, 1);
        up = 1'b1;
        #1 check("rco_up_follow", rco, 1);
        up = 1'b0;
        #1 check("rco_down_follow", rco, 0);

        // Priority: clear beats load; out-of-range loads give zero; loads never pulse TCP.
        nload = 1'b0; d = 4'd3;
        tick();
        check("load_3", q, 3);
        nclr = 1'b0; d = 4'd5; up = 1'b1;
        tick();
        check("clr_wins_q", q, 0);
        check("clr_wins_tcp", tcp, 0);
        nclr = 1'b1;
        tick();
        check("load_5", q, 5);
        d = 4'd12;
        tick();
        check("load_12_q", q, 0);
        check("load_12_tcp", tcp, 0);
        d = 4'd9;
        tick();
        check("load_9_q", q, 9);
        check("load_9_tcp", tcp, 0);

        // Enables.
        nload = 1'b1; enp = 1'b0; ent = 1'b1; up = 1'b1;
        #1 check("enp0_rco", rco, 1);
        tick();
        check("enp0_hold", q, 9);
        ent = 1'b0;
        #1 check("ent0_rco", rco, 0);
        tick();
        check("ent0_hold", q, 9);
        enp = 1'b1;
        tick();
        check("enp1_ent0_hold", q, 9);
        check("enp1_ent0_rco", rco, 0);
        check("enp1_ent0_tcp", tcp, 0);

        // Asynchronous reset pulse between edges.
        nload = 1'b0; d = 4'd7;
        tick();
        check("load_7", q, 7);
        nload = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        nr = 1'b0;
        #1;
        check("async_q", q, 0);
        check("async_tcp", tcp, 0);
        #1 nr = 1'b1;
        tick();
        check("post_reset_q", q, 1);
        check("post_reset_tcp", tcp, 0);
        enp = 1'b0;

        // Two-stage cascade.
        c_nload = 1'b0; c_d = 8'h0D;
        tick();
        check("casc_load_0d", {qh, ql}, 8'h0D);
        c_nload = 1'b1; c_en = 1'b1;
        tick();
        tick();
        check("casc_0f", {qh, ql}, 8'h0F);
        check("casc_rco_lo", rco_lo, 1);
        tick();
        check("casc_10", {qh, ql}, 8'h10);
        check("casc_tcp_lo", tcp_lo, 1);
        c_en = 1'b0; c_nload = 1'b0; c_d = 8'hFD;
        tick();
        check("casc_load_fd", {qh, ql}, 8'hFD);
        c_nload = 1'b1; c_en = 1'b1;
        tick();
        tick();
        check("casc_ff", {qh, ql}, 8'hFF);
        check("casc_rco_hi", rco_hi, 1);
        tick();
        check("casc_00", {qh, ql}, 8'h00);
        check("casc_tcp_hi", tcp_hi, 1);
        c_en = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
